// File: rtl/cpu_types_pkg.sv
// Shared types for the pipelined MIPS core front end: PC-select codes
// driven by decode, the fetch-stage state encoding and the IF/ID record.
package cpu_types_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  // Same encoding control_unit drives onto the redirect select lines.
  typedef enum logic [2:0] {
    NEXT         = 3'd0,
    BRANCH       = 3'd1,
    JUMP         = 3'd2,
    JUMPREGISTER = 3'd3,
    PC_HALT      = 3'd4
  } pcsel_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] npc;
  } ifid_t;

  // True for the selects that move the PC somewhere other than PC+4.
  function automatic logic isRedirect(input pcsel_t sel);
    return (sel == BRANCH) || (sel == JUMP) || (sel == JUMPREGISTER);
  endfunction

  // Instruction addresses are always word aligned.
  function automatic logic [31:0] wordAlign(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's memory, redirect and IF/ID signals.
// master is the fetch unit's view; slave is the surrounding pipeline/memory.
interface fetch_unit_if;
  import cpu_types_pkg::*;

  logic        ihit;
  logic [31:0] imemload;
  logic        stall;
  pcsel_t      redir_sel;
  logic [31:0] redir_npc;
  logic [31:0] redir_imm;
  logic [31:0] redir_jdata;

  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        halted;
  logic [31:0] fetch_count;

  modport master (
    input  ihit, imemload, stall, redir_sel, redir_npc, redir_imm, redir_jdata,
    output imemREN, imemaddr, ifid_valid, ifid_instr, ifid_npc, halted, fetch_count
  );

  modport slave (
    output ihit, imemload, stall, redir_sel, redir_npc, redir_imm, redir_jdata,
    input  imemREN, imemaddr, ifid_valid, ifid_instr, ifid_npc, halted, fetch_count
  );

endinterface

// File: rtl/fetch_unit_npc_calc.sv
// Redirect-target mux and adder. Purely combinational: computes where the
// PC goes when decode resolves a branch, jump or jump-register.
module npc_calc
  import cpu_types_pkg::*;
(
  input  pcsel_t      sel_i,
  input  logic [31:0] npc_i,
  input  logic [31:0] imm_i,
  input  logic [31:0] jdata_i,
  output logic [31:0] target_o,
  output logic        redirect_o
);

  logic [31:0] rawTarget;

  // Pick the target for the active select; the low two bits are cleared afterwards.
  always_comb begin
    rawTarget = npc_i;
    unique case (sel_i)
      BRANCH:       rawTarget = npc_i + (imm_i << 2);
      JUMP:         rawTarget = {npc_i[31:28], jdata_i[25:0], 2'b00};
      JUMPREGISTER: rawTarget = jdata_i;
      default:      rawTarget = npc_i;
    endcase
  end

  assign target_o   = wordAlign(rawTarget);
  assign redirect_o = isRedirect(sel_i);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from imem, latches
// them into IF/ID, applies redirects from decode and honours hazard stalls.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_unit_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  ifid_t        ifid_q, ifid_d;
  logic [31:0]  count_q, count_d;

  logic [31:0]  redirTarget;
  logic         redirTaken;
  logic [31:0]  pcPlus4;

  npc_calc u_npc_calc (
    .sel_i      (bus.redir_sel),
    .npc_i      (bus.redir_npc),
    .imm_i      (bus.redir_imm),
    .jdata_i    (bus.redir_jdata),
    .target_o   (redirTarget),
    .redirect_o (redirTaken)
  );

  assign pcPlus4 = pc_q + PC_STEP;

  // Once halted, only reset brings the stage back to RUN.
  always_comb begin
    state_d = state_q;
    if (state_q == RUN && bus.redir_sel == PC_HALT) begin
      state_d = HALTED;
    end
  end

  // Next PC, IF/ID and counter in priority order: halt, redirect, stall, hit, bubble.
  always_comb begin
    pc_d    = pc_q;
    ifid_d  = ifid_q;
    count_d = count_q;
    if (state_q == RUN) begin
      if (bus.redir_sel == PC_HALT) begin
        ifid_d.valid = 1'b0;
        ifid_d.instr = '0;
      end else if (redirTaken) begin
        pc_d         = redirTarget;
        ifid_d.valid = 1'b0;
        ifid_d.instr = '0;
      end else if (!bus.stall) begin
        if (bus.ihit) begin
          ifid_d.valid = 1'b1;
          ifid_d.instr = bus.imemload;
          ifid_d.npc   = pcPlus4;
          pc_d         = pcPlus4;
          count_d      = count_q + 32'd1;
        end else begin
          ifid_d.valid = 1'b0;
        end
      end
    end
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // PC, IF/ID and fetch counter registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q    <= PC_INIT;
      ifid_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      count_q <= count_d;
    end
  end

  assign bus.imemREN     = (state_q == RUN);
  assign bus.imemaddr    = pc_q;
  assign bus.ifid_valid  = ifid_q.valid;
  assign bus.ifid_instr  = ifid_q.instr;
  assign bus.ifid_npc    = ifid_q.npc;
  assign bus.halted      = (state_q == HALTED);
  assign bus.fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with hand-derived
// expectations followed by a randomized run against a behavioural model.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fetch_unit_if bus ();

  fetch_unit #(.PC_INIT(32'h0000_0000)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs at a falling edge, let the rising edge act, return at the next falling edge.
  task automatic applyStimulus(input logic hit, input logic [31:0] word, input logic stl,
                               input pcsel_t sel, input logic [31:0] npc,
                               input logic [31:0] imm, input logic [31:0] jdata);
    bus.ihit        = hit;
    bus.imemload    = word;
    bus.stall       = stl;
    bus.redir_sel   = sel;
    bus.redir_npc   = npc;
    bus.redir_imm   = imm;
    bus.redir_jdata = jdata;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    bus.ihit        = 1'b0;
    bus.imemload    = '0;
    bus.stall       = 1'b0;
    bus.redir_sel   = NEXT;
    bus.redir_npc   = '0;
    bus.redir_imm   = '0;
    bus.redir_jdata = '0;
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (bus.imemaddr !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc actual=%h required=%h", bus.imemaddr, 32'h0); end
    checks++; if (bus.imemREN !== 1'b1) begin errors++; $display("[TB] FAIL reset_ren actual=%b required=1", bus.imemREN); end
    checks++; if (bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 32'h0 || bus.ifid_npc !== 32'h0) begin errors++; $display("[TB] FAIL reset_ifid actual=%b/%h/%h required=0/0/0", bus.ifid_valid, bus.ifid_instr, bus.ifid_npc); end
    checks++; if (bus.halted !== 1'b0 || bus.fetch_count !== 32'h0) begin errors++; $display("[TB] FAIL reset_halt_count actual=%b/%0d required=0/0", bus.halted, bus.fetch_count); end
  endtask

  task automatic test_sequential_fetch();
    logic [31:0] expAddr;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 32'h2001_0005, 1'b0, NEXT, '0, '0, '0);
      expAddr = 32'(i * 4);
      checks++; if (bus.imemaddr !== expAddr) begin errors++; $display("[TB] FAIL seq_addr%0d actual=%h required=%h", i, bus.imemaddr, expAddr); end
      checks++; if (bus.ifid_valid !== 1'b1 || bus.ifid_instr !== 32'h2001_0005 || bus.ifid_npc !== expAddr) begin errors++; $display("[TB] FAIL seq_ifid%0d actual=%b/%h/%h required=1/20010005/%h", i, bus.ifid_valid, bus.ifid_instr, bus.ifid_npc, expAddr); end
    end
    checks++; if (bus.fetch_count !== 32'd3) begin errors++; $display("[TB] FAIL seq_count actual=%0d required=3", bus.fetch_count); end
  endtask

  task automatic test_stall();
    applyStimulus(1'b1, 32'h0000_0011, 1'b0, NEXT, '0, '0, '0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b1, NEXT, '0, '0, '0);
      checks++; if (bus.imemaddr !== 32'h10) begin errors++; $display("[TB] FAIL stall_pc actual=%h required=10", bus.imemaddr); end
      checks++; if (bus.ifid_valid !== 1'b1 || bus.ifid_instr !== 32'h0000_0011 || bus.ifid_npc !== 32'h10) begin errors++; $display("[TB] FAIL stall_ifid actual=%b/%h/%h required=1/00000011/10", bus.ifid_valid, bus.ifid_instr, bus.ifid_npc); end
      checks++; if (bus.fetch_count !== 32'd4) begin errors++; $display("[TB] FAIL stall_count actual=%0d required=4", bus.fetch_count); end
    end
    applyStimulus(1'b1, 32'h0000_0022, 1'b0, NEXT, '0, '0, '0);
    checks++; if (bus.imemaddr !== 32'h14 || bus.ifid_npc !== 32'h14 || bus.ifid_instr !== 32'h22) begin errors++; $display("[TB] FAIL stall_resume actual=%h/%h/%h required=14/14/22", bus.imemaddr, bus.ifid_npc, bus.ifid_instr); end
    checks++; if (bus.fetch_count !== 32'd5) begin errors++; $display("[TB] FAIL stall_resume_count actual=%0d required=5", bus.fetch_count); end
  endtask

  task automatic test_branch();
    applyStimulus(1'b1, 32'h1234_5678, 1'b1, BRANCH, 32'h20, 32'hFFFF_FFFE, '0);
    checks++; if (bus.imemaddr !== 32'h18) begin errors++; $display("[TB] FAIL branch_pc actual=%h required=18", bus.imemaddr); end
    checks++; if (bus.ifid_valid !== 1'b0 || bus.ifid_instr !== 32'h0) begin errors++; $display("[TB] FAIL branch_flush actual=%b/%h required=0/0", bus.ifid_valid, bus.ifid_instr); end
    checks++; if (bus.fetch_count !== 32'd5) begin errors++; $display("[TB] FAIL branch_count actual=%0d required=5", bus.fetch_count); end
  endtask

  task automatic test_jump();
    applyStimulus(1'b1, 32'h0, 1'b0, JUMP, 32'h4000_0010, '0, 32'h0800_0040);
    checks++; if (bus.imemaddr !== 32'h4000_0100) begin errors++; $display("[TB] FAIL jump_pc actual=%h required=40000100", bus.imemaddr); end
    applyStimulus(1'b0, 32'h0, 1'b0, JUMPREGISTER, '0, '0, 32'h0000_0123);
    checks++; if (bus.imemaddr !== 32'h120) begin errors++; $display("[TB] FAIL jr_pc actual=%h required=120", bus.imemaddr); end
    applyStimulus(1'b0, 32'h0, 1'b0, JUMPREGISTER, '0, '0, 32'hFFFF_FFFF);
    checks++; if (bus.imemaddr !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL jr_top actual=%h required=fffffffc", bus.imemaddr); end
    applyStimulus(1'b1, 32'h0000_0033, 1'b0, NEXT, '0, '0, '0);
    checks++; if (bus.imemaddr !== 32'h0 || bus.ifid_npc !== 32'h0) begin errors++; $display("[TB] FAIL pc_wrap actual=%h/%h required=0/0", bus.imemaddr, bus.ifid_npc); end
    checks++; if (bus.fetch_count !== 32'd6) begin errors++; $display("[TB] FAIL wrap_count actual=%0d required=6", bus.fetch_count); end
  endtask

  task automatic test_halt();
    applyStimulus(1'b1, 32'h44, 1'b0, NEXT, '0, '0, '0);
    applyStimulus(1'b1, 32'h55, 1'b0, NEXT, '0, '0, '0);
    applyStimulus(1'b1, 32'h66, 1'b1, PC_HALT, '0, '0, '0);
    checks++; if (bus.halted !== 1'b1 || bus.imemREN !== 1'b0) begin errors++; $display("[TB] FAIL halt_flags actual=%b/%b required=1/0", bus.halted, bus.imemREN); end
    checks++; if (bus.ifid_valid !== 1'b0 || bus.imemaddr !== 32'h8) begin errors++; $display("[TB] FAIL halt_state actual=%b/%h required=0/8", bus.ifid_valid, bus.imemaddr); end
    applyStimulus(1'b1, 32'h77, 1'b0, BRANCH, 32'h20, 32'h4, '0);
    applyStimulus(1'b1, 32'h88, 1'b0, NEXT, '0, '0, '0);
    checks++; if (bus.imemaddr !== 32'h8 || bus.fetch_count !== 32'd8 || bus.halted !== 1'b1 || bus.ifid_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_frozen actual=%h/%0d/%b/%b required=8/8/1/0", bus.imemaddr, bus.fetch_count, bus.halted, bus.ifid_valid); end
  endtask

  task automatic test_reset_while_halted();
    bus.ihit      = 1'b0;
    bus.stall     = 1'b0;
    bus.redir_sel = NEXT;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.imemaddr !== 32'h0 || bus.fetch_count !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_pc_count actual=%h/%0d required=0/0", bus.imemaddr, bus.fetch_count); end
    checks++; if (bus.halted !== 1'b0 || bus.imemREN !== 1'b1 || bus.ifid_valid !== 1'b0 || bus.ifid_npc !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_flags actual=%b/%b/%b/%h required=0/1/0/0", bus.halted, bus.imemREN, bus.ifid_valid, bus.ifid_npc); end
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b1, 32'h99, 1'b0, NEXT, '0, '0, '0);
    checks++; if (bus.imemaddr !== 32'h4 || bus.fetch_count !== 32'd1 || bus.ifid_instr !== 32'h99) begin errors++; $display("[TB] FAIL resume_after_reset actual=%h/%0d/%h required=4/1/99", bus.imemaddr, bus.fetch_count, bus.ifid_instr); end
  endtask

  task automatic test_random();
    logic [31:0] mPc, mInstr, mNpc, mCount, target, word, npc, imm, jdata;
    logic        mValid, mHalted, hit, stl;
    pcsel_t      sel;
    int          r, haltAge;
    doReset();
    mPc = 32'h0; mInstr = '0; mNpc = '0; mCount = '0; mValid = 1'b0; mHalted = 1'b0; haltAge = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (mHalted && haltAge >= 3) begin
        doReset();
        mPc = 32'h0; mInstr = '0; mNpc = '0; mCount = '0; mValid = 1'b0; mHalted = 1'b0; haltAge = 0;
      end
      hit   = ($urandom_range(0, 3) != 0);
      stl   = ($urandom_range(0, 4) == 0);
      word  = $urandom;
      npc   = {$urandom, 2'b00} ;
      r     = int'($urandom_range(0, 65535));
      imm   = 32'(signed'(16'(r)));
      jdata = $urandom;
      r     = int'($urandom_range(0, 99));
      sel   = (r < 70) ? NEXT : (r < 78) ? BRANCH : (r < 85) ? JUMP : (r < 93) ? JUMPREGISTER : (r < 96) ? PC_HALT : NEXT;
      applyStimulus(hit, word, stl, sel, npc, imm, jdata);
      if (mHalted) begin
        haltAge++;
      end else if (sel == PC_HALT) begin
        mHalted = 1'b1; mValid = 1'b0; mInstr = '0;
      end else if (sel == BRANCH || sel == JUMP || sel == JUMPREGISTER) begin
        if (sel == BRANCH)      target = npc + imm * 4;
        else if (sel == JUMP)   target = {npc[31:28], jdata[25:0], 2'b00};
        else                    target = jdata;
        mPc = target & 32'hFFFF_FFFC; mValid = 1'b0; mInstr = '0;
      end else if (stl) begin
        mPc = mPc;
      end else if (hit) begin
        mPc = mPc + 4; mValid = 1'b1; mInstr = word; mNpc = mPc; mCount = mCount + 1;
      end else begin
        mValid = 1'b0;
      end
      checks++; if (bus.imemaddr !== mPc || bus.imemREN !== !mHalted || bus.halted !== mHalted) begin errors++; $display("[TB] FAIL rand_pc_state cyc=%0d actual=%h/%b/%b required=%h/%b/%b", cyc, bus.imemaddr, bus.imemREN, bus.halted, mPc, !mHalted, mHalted); end
      checks++; if (bus.ifid_valid !== mValid || bus.ifid_instr !== mInstr || bus.ifid_npc !== mNpc) begin errors++; $display("[TB] FAIL rand_ifid cyc=%0d actual=%b/%h/%h required=%b/%h/%h", cyc, bus.ifid_valid, bus.ifid_instr, bus.ifid_npc, mValid, mInstr, mNpc); end
      checks++; if (bus.fetch_count !== mCount) begin errors++; $display("[TB] FAIL rand_count cyc=%0d actual=%0d required=%0d", cyc, bus.fetch_count, mCount); end
    end
  endtask

  // Run the scenarios in order, then report.
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    test_reset();
    test_sequential_fetch();
    test_stall();
    test_branch();
    test_jump();
    test_halt();
    test_reset_while_halted();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a run that never finishes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
